store_buffer: RTL and testbench



---
 rtl/store_buffer_if.sv | 35 +++
 rtl/store_buffer.sv | 129 ++++++++++++
 tb/tb_store_buffer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store-side, load-hazard and memory-write signals of the store buffer.
// The slave modport is the buffer itself; the master is its CPU/memory environment.
interface store_buffer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          st_valid;
   logic          st_ready;
   logic [31:0]   st_addr;
   logic [31:0]   st_data;
   logic [1:0]    st_size;
   logic          st_error;
   logic [31:0]   ld_addr;
   logic          ld_hazard;
   logic          empty;
   logic [CW-1:0] count;
   logic [2:0]    bytes_to_write;
   logic [31:0]   write_addr;
   logic [31:0]   write_data;
   logic          write_activate;
   logic          write_done;

   modport slave (
      input  st_valid, st_addr, st_data, st_size, ld_addr, write_done,
      output st_ready, st_error, ld_hazard, empty, count,
             bytes_to_write, write_addr, write_data, write_activate
   );

   modport master (
      output st_valid, st_addr, st_data, st_size, ld_addr, write_done,
      input  st_ready, st_error, ld_hazard, empty, count,
             bytes_to_write, write_addr, write_data, write_activate
   );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: DEPTH-entry FIFO draining one store at a time to the byte-granular memory write port.
// Latency: first write_activate one cycle after an accept into an idle buffer; backpressure: st_ready low when full.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   store_buffer_if.slave sb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [2:0]  bytes;
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t        state_q, state_d;
   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          st_error_q, st_error_d;
   logic          accept, push, pop;
   logic [2:0]    st_bytes;
   logic          hazard;
   entry_t        head;

   // Last byte may fall in the next word, so both ends of the store are compared.
   function automatic logic entry_hits(entry_t e, logic [29:0] word);
      logic [31:0] last;
      last = e.addr + {29'd0, e.bytes} - 32'd1;
      return (e.addr[31:2] == word) || (last[31:2] == word);
   endfunction

   assign sb.st_ready = (count_q < CW'(DEPTH));
   assign accept      = sb.st_valid && sb.st_ready;
   assign push        = accept && (sb.st_size != 2'd3);
   assign head        = mem_q[rd_ptr_q];

   always_comb begin
      st_bytes = 3'd0;
      case (sb.st_size)
         2'd0:    st_bytes = 3'd1;
         2'd1:    st_bytes = 3'd2;
         2'd2:    st_bytes = 3'd4;
         default: st_bytes = 3'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE:    if (count_q != '0) state_d = ISSUE;
         ISSUE: begin
            if (sb.write_done) begin
               pop     = 1'b1;
               state_d = GAP;
            end
         end
         GAP:     state_d = (count_q != '0) ? ISSUE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      st_error_d = accept && (sb.st_size == 2'd3);
      if (push) begin
         mem_d[wr_ptr_q] = '{bytes: st_bytes, addr: sb.st_addr, data: sb.st_data};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // An entry is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(PW'(i) - rd_ptr_q) < count_q) && entry_hits(mem_q[i], sb.ld_addr[31:2])) begin
            hazard = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         st_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         st_error_q <= st_error_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign sb.write_activate = (state_q == ISSUE);
   assign sb.bytes_to_write = sb.write_activate ? head.bytes : 3'd0;
   assign sb.write_addr     = sb.write_activate ? head.addr  : 32'd0;
   assign sb.write_data     = sb.write_activate ? head.data  : 32'd0;
   assign sb.st_error       = st_error_q;
   assign sb.ld_hazard      = hazard;
   assign sb.empty          = (count_q == '0);
   assign sb.count          = count_q;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed stores, scoreboard of expected memory writes checked by a memory responder.
module tb_store_buffer;
   localparam int DEPTH = 4;

   typedef struct {
      logic [2:0]  bytes;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   store_buffer_if #(.DEPTH(DEPTH)) bus ();

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t        exp_q[$];
   logic [7:0]  mem [logic [31:0]];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          hold = 1'b0;
   bit          flush = 1'b0;
   bit          mon_flushed = 1'b0;
   bit          chk_gap = 1'b0;
   bit          want_next = 1'b0;
   int          lat = 2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
   endfunction

   function automatic logic [2:0] size_bytes(input logic [1:0] s);
      return (s == 2'd0) ? 3'd1 : (s == 2'd1) ? 3'd2 : 3'd4;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      int k = 0;
      bus.st_valid = 1'b1;
      bus.st_addr  = a;
      bus.st_data  = d;
      bus.st_size  = s;
      while (!bus.st_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!bus.st_ready) begin
         chk("push_timeout", 32'(bus.st_ready), 1);
      end else if (s != 2'd3) begin
         exp_q.push_back('{bytes: size_bytes(s), addr: a, data: d});
      end
      @(negedge clk);
      bus.st_valid = 1'b0;
   endtask

   task automatic wait_drained(input string name);
      int k = 0;
      while (!(bus.empty && exp_q.size() == 0 && !bus.write_activate) && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(bus.empty && exp_q.size() == 0), 1);
   endtask

   // Memory responder: pops the expected write, checks it stays stable, then pulses write_done.
   initial begin : monitor
      exp_t e;
      int   k;
      bit   aborted;
      bus.write_done = 1'b0;
      forever begin
         @(negedge clk);
         if (want_next) begin
            want_next = 1'b0;
            chk("gap_one_cycle", 32'(bus.write_activate), 1);
         end
         aborted = 1'b0;
         if (!flush && bus.write_activate) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write_addr", bus.write_addr, 32'hdead_beef);
            end else begin
               e = exp_q.pop_front();
               chk("wr_bytes", 32'(bus.bytes_to_write), 32'(e.bytes));
               chk("wr_addr", bus.write_addr, e.addr);
               chk("wr_data", bus.write_data, e.data);
               k = 0;
               while ((hold || k < lat) && k < 2000) begin
                  @(negedge clk);
                  k++;
                  if (flush) begin
                     aborted = 1'b1;
                     break;
                  end
                  chk("issue_stable", 32'(bus.write_activate && bus.bytes_to_write == e.bytes &&
                      bus.write_addr == e.addr && bus.write_data == e.data), 1);
               end
               if (!aborted) begin
                  for (int b = 0; b < int'(e.bytes); b++) mem[e.addr + 32'(b)] = e.data[8*b +: 8];
                  bus.write_done = 1'b1;
                  @(negedge clk);
                  bus.write_done = 1'b0;
                  chk("gap_low", 32'(bus.write_activate), 0);
                  want_next = chk_gap && (exp_q.size() > 0);
               end
            end
         end
         if (flush) begin
            mon_flushed = 1'b1;
            k = 0;
            while (flush && k < 1000) begin
               @(negedge clk);
               k++;
            end
            mon_flushed = 1'b0;
            bus.write_done = 1'b1;
            @(negedge clk);
            bus.write_done = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin : stim
      int k;
      bus.st_valid = 1'b0;
      bus.st_addr  = '0;
      bus.st_data  = '0;
      bus.st_size  = '0;
      bus.ld_addr  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_activate", 32'(bus.write_activate), 0);
      chk("rst_bytes", 32'(bus.bytes_to_write), 0);
      chk("rst_addr", bus.write_addr, 0);
      chk("rst_data", bus.write_data, 0);
      chk("rst_st_error", 32'(bus.st_error), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_st_ready", 32'(bus.st_ready), 1);
      chk("rst_hazard", 32'(bus.ld_hazard), 0);

      // Single word store and first-write latency
      push(32'h0000_0100, 32'hffff_ffff, 2'd2);
      chk("lat_idle", 32'(bus.write_activate), 0);
      @(negedge clk);
      chk("lat_issue", 32'(bus.write_activate), 1);
      chk("lat_bytes", 32'(bus.bytes_to_write), 4);
      wait_drained("single_drain");
      chk("single_mem", rd_word(32'h0000_0100), 32'hffff_ffff);

      // Mixed sizes queued back-to-back, one GAP between writes
      hold = 1'b1;
      chk_gap = 1'b1;
      push(32'h0000_0100, 32'hffff_ffff, 2'd2);
      push(32'h0000_0100, 32'h0000_0000, 2'd0);
      push(32'h0000_0100, 32'h0000_0000, 2'd1);
      chk("mixed_count", 32'(bus.count), 3);
      hold = 1'b0;
      wait_drained("mixed_drain");
      chk_gap = 1'b0;
      chk("mixed_mem", rd_word(32'h0000_0100), 32'hffff_0000);

      // Fill with write_done held off
      hold = 1'b1;
      for (int i = 0; i < DEPTH; i++) push(32'h0000_0010 + 32'(4 * i), 32'(i + 1), 2'd2);
      chk("full_count", 32'(bus.count), DEPTH);
      chk("full_ready", 32'(bus.st_ready), 0);
      chk("full_empty", 32'(bus.empty), 0);
      bus.st_valid = 1'b1;
      bus.st_addr  = 32'h0000_0050;
      bus.st_data  = 32'h5555_5555;
      bus.st_size  = 2'd2;
      @(negedge clk);
      bus.st_valid = 1'b0;
      chk("full_reject_count", 32'(bus.count), DEPTH);
      hold = 1'b0;
      k = 0;
      while (bus.count == 3'(DEPTH) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("free_one_count", 32'(bus.count), DEPTH - 1);
      chk("free_one_ready", 32'(bus.st_ready), 1);
      wait_drained("fill_drain");
      chk("fill_mem_last", rd_word(32'h0000_001c), 32'h0000_0004);

      // Load hazard from a misaligned half store spanning two words
      hold = 1'b1;
      push(32'h0000_0103, 32'h0000_beef, 2'd1);
      bus.ld_addr = 32'h0000_0100; #1;
      chk("haz_0100", 32'(bus.ld_hazard), 1);
      bus.ld_addr = 32'h0000_0104; #1;
      chk("haz_0104", 32'(bus.ld_hazard), 1);
      bus.ld_addr = 32'h0000_0108; #1;
      chk("haz_0108", 32'(bus.ld_hazard), 0);
      bus.ld_addr = 32'h0000_00fc; #1;
      chk("haz_00fc", 32'(bus.ld_hazard), 0);
      bus.ld_addr = 32'h0000_0104;
      @(negedge clk);
      hold = 1'b0;
      k = 0;
      while (!bus.write_done && k < 200) begin
         @(posedge clk);
         k++;
      end
      chk("haz_done_seen", 32'(bus.write_done), 1);
      chk("haz_before_pop", 32'(bus.ld_hazard), 1);
      @(negedge clk);
      chk("haz_cleared", 32'(bus.ld_hazard), 0);
      wait_drained("haz_drain");
      chk("haz_mem", rd_word(32'h0000_0100), 32'hefff_0000);
      chk("haz_mem_hi", 32'(mem[32'h0000_0104]), 32'h0000_00be);

      // Illegal size
      push(32'h0000_0200, 32'h1234_5678, 2'd3);
      chk("illegal_error", 32'(bus.st_error), 1);
      chk("illegal_count", 32'(bus.count), 0);
      @(negedge clk);
      chk("illegal_error_pulse", 32'(bus.st_error), 0);
      repeat (3) @(negedge clk);
      chk("illegal_no_write", 32'(bus.write_activate), 0);
      chk("illegal_empty", 32'(bus.empty), 1);

      // Reset during an in-flight write with queued stores
      hold = 1'b1;
      push(32'h0000_0300, 32'h0000_0aaa, 2'd2);
      push(32'h0000_0304, 32'h0000_0bbb, 2'd2);
      push(32'h0000_0308, 32'h0000_0ccc, 2'd2);
      k = 0;
      while (!bus.write_activate && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("rmw_issue", 32'(bus.write_activate), 1);
      chk("rmw_count", 32'(bus.count), 3);
      flush = 1'b1;
      rst   = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      chk("rmw_activate", 32'(bus.write_activate), 0);
      chk("rmw_count_zero", 32'(bus.count), 0);
      chk("rmw_empty", 32'(bus.empty), 1);
      chk("rmw_ready", 32'(bus.st_ready), 1);
      k = 0;
      while (!mon_flushed && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("rmw_mon_ack", 32'(mon_flushed), 1);
      flush = 1'b0;
      hold  = 1'b0;
      repeat (4) @(negedge clk);
      chk("late_done_count", 32'(bus.count), 0);
      chk("late_done_empty", 32'(bus.empty), 1);
      chk("late_done_idle", 32'(bus.write_activate), 0);

      // Normal operation resumes after the reset
      push(32'h0000_0400, 32'ha5a5_a5a5, 2'd2);
      wait_drained("post_rst_drain");
      chk("post_rst_mem", rd_word(32'h0000_0400), 32'ha5a5_a5a5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
